dmem_write_buffer: RTL

//  Posted-write buffer between the pipelined CPU's data port and the external data-memory bus.
//  The external bus is the same addr/data/wen bus the result-checking bench monitors.

---
 rtl/wbuf_pkg.sv | 7 +
 rtl/wbuf_entry_array.sv | 55 +++++
 rtl/dmem_write_buffer.sv | 67 ++++++
 3 files changed

// File: rtl/wbuf_pkg.sv
// wbuf_pkg: shared FSM state type and pointer-width helper for the data-memory write buffer
package wbuf_pkg;
   typedef enum logic [2:0] {IDLE, WRITE, WGAP, READ, RGAP} state_t;
   function automatic int ptr_w(input int depth);
      return $clog2(depth);
   endfunction
endpackage

// File: rtl/wbuf_entry_array.sv
// wbuf_entry_array: circular {addr,data} store FIFO with a youngest-match address search
module wbuf_entry_array
   import wbuf_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW = 30,
   parameter int DW = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push,
   input  logic                      pop,
   input  logic [AW-1:0]             push_addr,
   input  logic [DW-1:0]             push_data,
   input  logic [AW-1:0]             search_addr,
   output logic [AW-1:0]             head_addr,
   output logic [DW-1:0]             head_data,
   output logic                      full,
   output logic [ptr_w(DEPTH):0]     count,
   output logic                      hit,
   output logic [DW-1:0]             hit_data
);
   localparam int PW = ptr_w(DEPTH);
   logic [AW-1:0] addr_q [DEPTH];
   logic [DW-1:0] data_q [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   assign full = count == (PW+1)'(DEPTH);
   assign head_addr = addr_q[rd_ptr];
   assign head_data = data_q[rd_ptr];
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (PW+1)'(push) - (PW+1)'(pop);
      end
   always_ff @(posedge clk)
      if (push) begin
         addr_q[wr_ptr] <= push_addr;
         data_q[wr_ptr] <= push_data;
      end
   // Walk oldest to youngest so the last valid match (youngest) wins.
   always_comb begin
      hit = 1'b0;
      hit_data = '0;
      for (int i = 0; i < DEPTH; i++)
         if ((PW+1)'(i) < count && addr_q[rd_ptr + PW'(i)] == search_addr) begin
            hit = 1'b1;
            hit_data = data_q[rd_ptr + PW'(i)];
         end
   end
endmodule

// File: rtl/dmem_write_buffer.sv
// dmem_write_buffer: posted-write buffer draining CPU stores to the memory bus with idle gaps
module dmem_write_buffer
   import wbuf_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW = 30,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          proc_read,
   input  logic          proc_write,
   input  logic [AW-1:0] proc_addr,
   input  logic [DW-1:0] proc_wdata,
   output logic [DW-1:0] proc_rdata,
   output logic          proc_stall,
   output logic          mem_read,
   output logic          mem_write,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ready
);
   state_t state, next;
   logic push, pop, full, hit, rd_done;
   logic [AW-1:0] head_addr;
   logic [DW-1:0] head_data, hit_data;
   logic [ptr_w(DEPTH):0] count;
   assign push = proc_write && !full;
   assign pop = state == WRITE && mem_ready;
   assign rd_done = state == READ && mem_ready;
   assign proc_stall = (proc_write && full) || (proc_read && !hit && !rd_done);
   assign proc_rdata = !proc_read ? '0 : hit ? hit_data : rd_done ? mem_rdata : '0;
   wbuf_entry_array #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_arr (
      .clk(clk), .rst(rst), .push(push), .pop(pop),
      .push_addr(proc_addr), .push_data(proc_wdata), .search_addr(proc_addr),
      .head_addr(head_addr), .head_data(head_data), .full(full), .count(count),
      .hit(hit), .hit_data(hit_data)
   );
   // Buffered stores always go out before a missing load is issued.
   always_comb begin
      next = IDLE;
      unique case (state)
         IDLE:    next = count != '0 ? WRITE : (proc_read && !hit) ? READ : IDLE;
         WRITE:   next = mem_ready ? WGAP : WRITE;
         READ:    next = mem_ready ? RGAP : READ;
         default: next = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= IDLE;
         mem_write <= 1'b0;
         mem_read <= 1'b0;
         mem_addr <= '0;
         mem_wdata <= '0;
      end else begin
         state <= next;
         mem_write <= next == WRITE;
         mem_read <= next == READ;
         if (state == IDLE && next == WRITE) begin
            mem_addr <= head_addr;
            mem_wdata <= head_data;
         end else if (state == IDLE && next == READ)
            mem_addr <= proc_addr;
      end
endmodule
